pcpi_shared_mem: RTL

Synthesisable, parametrised shared word memory serving NPORTS independent valid/ready request ports: the CPU fetch/data port, the vector coprocessor memory port and any further masters. Requests are serialised through a round-robin arbiter, with configurable depth, configurable wait states, byte-strobe writes and an out-of-range error response. It replaces the per-master ad-hoc memory models with one block that guarantees coherent ordering between masters.

---
 rtl/pcpi_mem_pkg.sv | 17 +
 rtl/pcpi_rr_arbiter.sv | 31 +++
 rtl/pcpi_shared_mem.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pcpi_mem_pkg.sv
// Shared definitions for the multi-port shared word memory: FSM encoding,
// word geometry and the byte-address to word-index mapping.
package pcpi_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] ERR_RDATA  = 32'h0;

    // Byte address to word index; the low two address bits are ignored.
    function automatic logic [29:0] addr_to_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/pcpi_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr
// wins. The pointer register lives in the parent.
module pcpi_rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!gnt_vld && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcpi_shared_mem.sv
// Shared word memory behind NPORTS valid/ready ports, serialised by a
// round-robin arbiter, with optional wait states and byte-strobe writes.
module pcpi_shared_mem
    import pcpi_mem_pkg::*;
#(
    parameter int NPORTS      = 2,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NPORTS-1:0]      req_valid,
    output logic [NPORTS-1:0]      req_ready,
    input  logic [32*NPORTS-1:0]   req_addr,
    input  logic [32*NPORTS-1:0]   req_wdata,
    input  logic [4*NPORTS-1:0]    req_wstrb,
    output logic [32*NPORTS-1:0]   req_rdata,
    output logic [NPORTS-1:0]      req_err,
    output logic                   busy
);

    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]               state, state_nxt;
    logic [IW-1:0]            ptr, gnt_idx, lat_port;
    logic [NPORTS-1:0]        gnt;
    logic                     gnt_vld;
    logic [31:0]              sel_addr, sel_wdata;
    logic [3:0]               sel_wstrb;
    logic [29:0]              lat_idx;
    logic [31:0]              lat_wdata;
    logic [3:0]               lat_wstrb;
    logic [3:0]               wait_cnt;
    logic [NPORTS-1:0][31:0]  rdata_q;
    logic [NPORTS-1:0]        err_q;
    logic                     in_range;
    logic [31:0]              rd_word;
    logic [31:0]              mem [DEPTH_WORDS];

    pcpi_rr_arbiter #(.N(NPORTS)) u_arb (
        .req     (req_valid & ~req_ready),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (gnt[p]) begin
                sel_addr  = req_addr[32*p +: 32];
                sel_wdata = req_wdata[32*p +: 32];
                sel_wstrb = req_wstrb[4*p +: 4];
            end
        end
    end

    assign in_range = lat_idx < 30'(DEPTH_WORDS);
    assign rd_word  = in_range ? mem[lat_idx[AW-1:0]] : ERR_RDATA;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (gnt_vld) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: the granted port sees live read data during RESP, others hold.
    always_comb begin
        busy      = (state != ST_IDLE);
        req_ready = '0;
        req_rdata = rdata_q;
        req_err   = err_q;
        if (state == ST_RESP) begin
            req_ready[lat_port]           = 1'b1;
            req_rdata[32*lat_port +: 32]  = rd_word;
            req_err[lat_port]             = !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr       <= '0;
            wait_cnt  <= '0;
            lat_port  <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
        end else begin
            if (state == ST_IDLE && gnt_vld) begin
                lat_port  <= gnt_idx;
                lat_idx   <= addr_to_index(sel_addr);
                lat_wdata <= sel_wdata;
                lat_wstrb <= sel_wstrb;
                ptr       <= (gnt_idx == IW'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
                wait_cnt  <= 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ST_RESP) begin
                rdata_q[lat_port] <= rd_word;
                err_q[lat_port]   <= !in_range;
            end
        end
    end

    // Write lands at the end of RESP, after the read-before-write data is shown.
    always_ff @(posedge clk) begin
        if (resetn && state == ST_RESP && in_range) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (lat_wstrb[b]) mem[lat_idx[AW-1:0]][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

endmodule
